mempool_tcdm_link: RTL and testbench



---
 rtl/mempool_tcdm_link.sv | 171 +++++++++++++++++
 tb/tb_mempool_tcdm_link.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mempool_tcdm_link.sv
// Credit-limited elastic buffer for one remote TCDM link between two MemPool groups.
// Define MEMPOOL_LINK_PERF_EN to build the saturating initiator-stall counter.

module mempool_tcdm_link_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wptr;
    logic [PtrW-1:0]  r_rptr;
    logic [CntW-1:0]  r_cnt;
    logic             w_push;
    logic             w_pop;

    assign empty_o = (r_cnt == '0);
    assign full_o  = (r_cnt == CntW'(Depth));
    assign data_o  = r_mem[r_rptr];
    assign w_pop   = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
    assign w_push  = push_i && (!full_o || w_pop);

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == LastPtr) ? '0 : r_wptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == LastPtr) ? '0 : r_rptr + PtrW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CntW'(1);
                2'b01:   r_cnt <= r_cnt - CntW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

module mempool_tcdm_link #(
    parameter int unsigned ReqWidth       = 64,
    parameter int unsigned RespWidth      = 40,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ReqWidth-1:0]  req_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    output logic [ReqWidth-1:0]  req_o,
    output logic                 req_valid_o,
    input  logic                 req_ready_i,
    input  logic [RespWidth-1:0] resp_i,
    input  logic                 resp_valid_i,
    output logic                 resp_ready_o,
    output logic [RespWidth-1:0] resp_o,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic [CntWidth-1:0]  outstanding_o,
    output logic [31:0]          stall_cnt_o
);
    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

    logic                w_req_full;
    logic                w_req_empty;
    logic                w_resp_full;
    logic                w_resp_empty;
    logic                w_req_push;
    logic                w_req_pop;
    logic                w_resp_push;
    logic                w_resp_hs;
    logic [CntWidth-1:0] r_outstanding;

    // Credits bound the in-flight count to the response queue depth, so the
    // response side never has to push back on the target group.
    assign req_ready_o  = !rst_i && !w_req_full && (r_outstanding < MaxCnt);
    assign resp_ready_o = !rst_i && !w_resp_full;
    assign req_valid_o  = !w_req_empty;
    assign resp_valid_o = !w_resp_empty;

    assign w_req_push  = req_valid_i && req_ready_o;
    assign w_req_pop   = req_valid_o && req_ready_i;
    assign w_resp_push = resp_valid_i && resp_ready_o;
    assign w_resp_hs   = resp_valid_o && resp_ready_i;

    mempool_tcdm_link_fifo #(
        .Width (ReqWidth),
        .Depth (2)
    ) i_req_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_req_push),
        .data_i  (req_i),
        .pop_i   (w_req_pop),
        .data_o  (req_o),
        .empty_o (w_req_empty),
        .full_o  (w_req_full)
    );

    mempool_tcdm_link_fifo #(
        .Width (RespWidth),
        .Depth (MaxOutstanding)
    ) i_resp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_resp_push),
        .data_i  (resp_i),
        .pop_i   (w_resp_hs),
        .data_o  (resp_o),
        .empty_o (w_resp_empty),
        .full_o  (w_resp_full)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_outstanding <= '0;
        end else if (w_req_push && !w_resp_hs) begin
            r_outstanding <= r_outstanding + CntWidth'(1);
        end else if (!w_req_push && w_resp_hs && (r_outstanding != '0)) begin
            r_outstanding <= r_outstanding - CntWidth'(1);
        end
    end

    assign outstanding_o = r_outstanding;

    // A response with nothing in flight means the target broke the protocol.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_resp_hs && !w_req_push) begin
            assert (r_outstanding != '0);
        end
    end

`ifdef MEMPOOL_LINK_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if (req_valid_i && !req_ready_o && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    assign stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_mempool_tcdm_link.sv
// Scoreboard bench for mempool_tcdm_link: queue-level reference model checked every cycle.

module tb_mempool_tcdm_link;
    localparam int MAX = 4;
    localparam int RW  = 64;
    localparam int SW  = 40;
    localparam int CW  = $clog2(MAX + 1);
`ifdef MEMPOOL_LINK_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic [RW-1:0] req_i = '0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [RW-1:0] req_o;
    logic          req_valid_o;
    logic          req_ready_i = 1'b0;
    logic [SW-1:0] resp_i = '0;
    logic          resp_valid_i = 1'b0;
    logic          resp_ready_o;
    logic [SW-1:0] resp_o;
    logic          resp_valid_o;
    logic          resp_ready_i = 1'b0;
    logic [CW-1:0] outstanding_o;
    logic [31:0]   stall_cnt_o;

    always #5 clk = ~clk;

    mempool_tcdm_link #(
        .ReqWidth       (RW),
        .RespWidth      (SW),
        .MaxOutstanding (MAX)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .req_i         (req_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_o         (req_o),
        .req_valid_o   (req_valid_o),
        .req_ready_i   (req_ready_i),
        .resp_i        (resp_i),
        .resp_valid_i  (resp_valid_i),
        .resp_ready_o  (resp_ready_o),
        .resp_o        (resp_o),
        .resp_valid_o  (resp_valid_o),
        .resp_ready_i  (resp_ready_i),
        .outstanding_o (outstanding_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    // Reference model: contents of both queues, the target's pending replies,
    // the in-flight count and the stall count.
    logic [RW-1:0] exp_req[$];
    logic [SW-1:0] exp_resp[$];
    logic [SW-1:0] tgt_pend[$];
    logic [RW-1:0] req_src[$];
    logic [SW-1:0] resp_src[$];
    int            m_out = 0;
    logic [31:0]   m_stall = '0;
    bit            hold_req = 0, hold_resp = 0;
    logic [RW-1:0] held_req;
    logic [SW-1:0] held_resp;
    bit            req_taken = 0;
    int            n_acc = 0, n_req_out = 0, n_resp_out = 0;
    int            req_budget = 0, req_pct = 100, tgt_pct = 100;
    bit            tgt_auto = 0;

    always @(negedge clk) begin : monitor
        bit            rq_rdy, rs_rdy, push, rpop;
        logic [63:0]   rnd;
        if (rst_i) begin
            chk("req_ready_in_reset", req_ready_o, 0);
            chk("resp_ready_in_reset", resp_ready_o, 0);
            exp_req.delete();
            exp_resp.delete();
            tgt_pend.delete();
            m_out = 0;
            m_stall = '0;
            hold_req = 0;
            hold_resp = 0;
            req_taken = 0;
        end else begin
            rq_rdy = (exp_req.size() < 2) && (m_out < MAX);
            rs_rdy = exp_resp.size() < MAX;
            chk("req_valid_o", req_valid_o, exp_req.size() != 0);
            chk("resp_valid_o", resp_valid_o, exp_resp.size() != 0);
            chk("req_ready_o", req_ready_o, rq_rdy);
            chk("resp_ready_o", resp_ready_o, rs_rdy);
            chk("outstanding_o", outstanding_o, m_out);
            chk("stall_cnt_o", stall_cnt_o, m_stall);
            if (hold_req)  chk("req_o_stable", req_o, held_req);
            if (hold_resp) chk("resp_o_stable", resp_o, held_resp);

            if (req_valid_o && req_ready_i) begin
                if (exp_req.size() == 0) chk("req_spurious", req_valid_o, 0);
                else chk("req_order", req_o, exp_req.pop_front());
                n_req_out++;
                rnd = {$urandom(), $urandom()};
                tgt_pend.push_back((resp_src.size() != 0) ? resp_src.pop_front() : rnd[SW-1:0]);
            end
            rpop = resp_valid_o && resp_ready_i;
            if (rpop) begin
                if (exp_resp.size() == 0) chk("resp_spurious", resp_valid_o, 0);
                else chk("resp_order", resp_o, exp_resp.pop_front());
                n_resp_out++;
            end
            if (resp_valid_i && rs_rdy) begin
                exp_resp.push_back(resp_i);
                if (tgt_pend.size() != 0) void'(tgt_pend.pop_front());
            end
            push = req_valid_i && rq_rdy;
            if (push) begin
                exp_req.push_back(req_i);
                n_acc++;
            end
            req_taken = push;
            m_out = m_out + int'(push) - int'(rpop);
            if (m_out < 0) m_out = 0;
            if (PERF && req_valid_i && !rq_rdy && (m_stall != 32'hFFFF_FFFF)) m_stall++;
            hold_req  = req_valid_o && !req_ready_i;
            held_req  = req_o;
            hold_resp = resp_valid_o && !resp_ready_i;
            held_resp = resp_o;
        end
    end

    // Initiator: holds each offered request until it is accepted.
    always @(posedge clk) begin
        #1;
        if (req_valid_i && !req_taken) begin
            req_valid_i = 1'b1;
        end else if (req_budget > 0 && $urandom_range(99) < req_pct) begin
            req_valid_i = 1'b1;
            req_i = (req_src.size() != 0) ? req_src.pop_front() : {$urandom(), $urandom()};
            req_budget--;
        end else begin
            req_valid_i = 1'b0;
        end
    end

    // Target: answers forwarded requests in order.
    always @(posedge clk) begin
        #1;
        if (tgt_auto && tgt_pend.size() != 0 && $urandom_range(99) < tgt_pct) begin
            resp_valid_i = 1'b1;
            resp_i = tgt_pend[0];
        end else begin
            resp_valid_i = 1'b0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic rand_phase(input int cycles);
        int k;
        req_pct = 70;
        tgt_pct = 60;
        tgt_auto = 1;
        req_budget = 100000;
        for (int i = 0; i < cycles; i++) begin
            step(1);
            req_ready_i  = ($urandom_range(3) != 0);
            resp_ready_i = ($urandom_range(3) != 0);
        end
        req_budget = 0;
        req_ready_i = 1'b1;
        resp_ready_i = 1'b1;
        tgt_pct = 100;
        k = 0;
        while (k < 200 && (req_valid_i || req_valid_o || resp_valid_o || outstanding_o != 0)) begin
            step(1);
            k++;
        end
        chk("drain_in_time", k < 200, 1);
        chk("drain_outstanding", outstanding_o, 0);
    endtask

    initial begin : main
        int a0, q0, p0;
        logic [31:0] s0;

        // Reset held for 3 cycles, then idle.
        step(3);
        rst_i = 1'b0;
        #1;
        chk("post_reset_req_ready", req_ready_o, 1);
        chk("post_reset_resp_ready", resp_ready_o, 1);
        chk("post_reset_req_valid", req_valid_o, 0);
        chk("post_reset_resp_valid", resp_valid_o, 0);
        chk("post_reset_outstanding", outstanding_o, 0);
        chk("post_reset_stall", stall_cnt_o, 0);

        // Credit limit: six offered, no responses returned.
        a0 = n_acc;
        req_ready_i = 1'b1;
        tgt_auto = 0;
        req_pct = 100;
        req_budget = 6;
        step(12);
        chk("credit_accepts", n_acc - a0, 4);
        chk("credit_outstanding", outstanding_o, MAX);
        chk("credit_req_ready", req_ready_o, 0);
        s0 = stall_cnt_o;
        step(3);
        chk("credit_stall_delta", stall_cnt_o - s0, PERF ? 3 : 0);

        // Responses flow: credit returns and the stalled requests go through.
        p0 = n_resp_out;
        tgt_auto = 1;
        tgt_pct = 100;
        resp_ready_i = 1'b1;
        step(20);
        chk("simul_accepts", n_acc - a0, 6);
        chk("simul_responses", n_resp_out - p0, 6);
        chk("simul_outstanding", outstanding_o, 0);

        // Request backpressure ordering.
        q0 = n_req_out;
        req_ready_i = 1'b0;
        req_src.push_back(64'hA);
        req_src.push_back(64'hB);
        req_budget = 2;
        step(6);
        chk("bp_req_ready", req_ready_o, 0);
        chk("bp_req_valid", req_valid_o, 1);
        chk("bp_head", req_o, 64'hA);
        req_ready_i = 1'b1;
        step(10);
        chk("bp_delivered", n_req_out - q0, 2);
        chk("bp_outstanding", outstanding_o, 0);

        // Response queue fills to depth while the initiator stalls.
        p0 = n_resp_out;
        resp_ready_i = 1'b0;
        for (int i = 1; i <= 4; i++) resp_src.push_back(SW'(i));
        req_budget = 4;
        step(10);
        chk("rq_resp_ready_full", resp_ready_o, 0);
        chk("rq_resp_valid", resp_valid_o, 1);
        chk("rq_head", resp_o, 40'h1);
        chk("rq_outstanding", outstanding_o, MAX);
        resp_ready_i = 1'b1;
        step(8);
        chk("rq_delivered", n_resp_out - p0, 4);
        chk("rq_outstanding_done", outstanding_o, 0);

        rand_phase(1500);

        // Reset with requests and responses queued.
        tgt_pct = 100;
        tgt_auto = 1;
        req_ready_i = 1'b1;
        resp_ready_i = 1'b0;
        req_pct = 100;
        req_budget = 3;
        step(10);
        req_ready_i = 1'b0;
        req_budget = 1;
        step(4);
        chk("mid_pre_req_valid", req_valid_o, 1);
        chk("mid_pre_resp_valid", resp_valid_o, 1);
        chk("mid_pre_outstanding", outstanding_o, MAX);
        rst_i = 1'b1;
        step(1);
        rst_i = 1'b0;
        #1;
        chk("mid_req_valid", req_valid_o, 0);
        chk("mid_resp_valid", resp_valid_o, 0);
        chk("mid_outstanding", outstanding_o, 0);
        q0 = n_req_out;
        p0 = n_resp_out;
        req_ready_i = 1'b1;
        resp_ready_i = 1'b1;
        step(5);
        chk("mid_no_req_out", n_req_out - q0, 0);
        chk("mid_no_resp_out", n_resp_out - p0, 0);
        chk("mid_idle_valid", req_valid_o || resp_valid_o, 0);

        rand_phase(300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end
endmodule
